// File: rtl/t5_pkg.sv
// Shared opcode constants, instruction-format enum and immediate decode for the t5 core.
package t5_pkg;

    localparam int unsigned ILEN  = 32;
    localparam int unsigned OPC_W = 5;

    localparam logic [OPC_W-1:0] OPC_LOAD     = 5'b00000;
    localparam logic [OPC_W-1:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [OPC_W-1:0] OPC_AUIPC    = 5'b00101;
    localparam logic [OPC_W-1:0] OPC_STORE    = 5'b01000;
    localparam logic [OPC_W-1:0] OPC_OP       = 5'b01100;
    localparam logic [OPC_W-1:0] OPC_LUI      = 5'b01101;
    localparam logic [OPC_W-1:0] OPC_BRANCH   = 5'b11000;
    localparam logic [OPC_W-1:0] OPC_JALR     = 5'b11001;
    localparam logic [OPC_W-1:0] OPC_JAL      = 5'b11011;
    localparam logic [OPC_W-1:0] OPC_SYSTEM   = 5'b11100;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_X
    } fmt_e;

    // FMT_X marks anything outside the supported base opcodes, including compressed encodings.
    function automatic fmt_e fmt_decode(input logic [6:0] op7);
        fmt_e f;
        f = FMT_X;
        if (op7[1:0] == 2'b11) begin
            case (op7[6:2])
                OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: f = FMT_I;
                OPC_STORE:          f = FMT_S;
                OPC_BRANCH:         f = FMT_B;
                OPC_AUIPC, OPC_LUI: f = FMT_U;
                OPC_JAL:            f = FMT_J;
                OPC_OP:             f = FMT_R;
                default:            f = FMT_X;
            endcase
        end
        return f;
    endfunction

    // Immediate sign-extended to 32 bits; wider datapaths extend further from bit 31.
    function automatic logic [ILEN-1:0] imm_decode(input logic [31:7] ins, input fmt_e fmt);
        logic [ILEN-1:0] imm;
        imm = '0;
        case (fmt)
            FMT_I:   imm = {{20{ins[31]}}, ins[31:20]};
            FMT_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            FMT_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            FMT_U:   imm = {ins[31:12], 12'b0};
            FMT_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/t5_immgen.sv
// Combinational immediate generator, shared by decode and the branch predictor.
module t5_immgen
    import t5_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:7]     i_idat,
    input  fmt_e            i_fmt,
    output logic [XLEN-1:0] o_imm_c
);

    logic [ILEN-1:0] w_imm32;

    assign w_imm32 = imm_decode(i_idat, i_fmt);
    assign o_imm_c = XLEN'($signed(w_imm32));

endmodule

// File: rtl/t5_dec.sv
// Decode/operand stage of the barrel-threaded t5 core with valid/ready handshake and per-hart PC pipeline.
module t5_dec
    import t5_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned HBIT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_vld,
    output logic            i_rdy,
    input  logic [XLEN-1:0] pc,
    input  logic [31:0]     idat,
    input  logic [XLEN-1:0] rs1d,
    input  logic [XLEN-1:0] rs2d,
    output logic            o_vld,
    input  logic            o_rdy,
    output logic [XLEN-1:0] op1,
    output logic [XLEN-1:0] op2,
    output logic [XLEN-1:0] cp1,
    output logic [XLEN-1:0] cp2,
    output logic [4:0]      aslc,
    output logic [2:0]      fun3,
    output logic [6:0]      fun7,
    output logic [4:0]      rd,
    output logic [HBIT-1:0] hid,
    output logic            ill,
    output logic [XLEN-1:0] pcn,
    output logic [XLEN-1:0] npc,
    output logic [XLEN-1:0] pc4
);

    localparam int unsigned UPW = XLEN - HBIT;

    logic             w_xin;
    logic             w_xout;
    fmt_e             w_fmt;
    logic             w_ill;
    logic [OPC_W-1:0] w_opc;
    logic [XLEN-1:0]  w_imm;
    logic [XLEN-1:0]  w_op1;
    logic [XLEN-1:0]  w_op2;
    logic [4:0]       w_rd;
    logic [UPW-1:0]   w_pc_hi;
    logic [XLEN-1:0]  w_pcn;

    logic             r_vld;
    logic [XLEN-1:0]  r_op1;
    logic [XLEN-1:0]  r_op2;
    logic [XLEN-1:0]  r_cp1;
    logic [XLEN-1:0]  r_cp2;
    logic [4:0]       r_aslc;
    logic [2:0]       r_fun3;
    logic [6:0]       r_fun7;
    logic [4:0]       r_rd;
    logic [HBIT-1:0]  r_hid;
    logic             r_ill;
    logic [XLEN-1:0]  r_pcn;
    logic [XLEN-1:0]  r_npc;
    logic [XLEN-1:0]  r_pc4;

    assign i_rdy  = !r_vld | o_rdy;
    assign w_xin  = i_vld & i_rdy;
    assign w_xout = r_vld & o_rdy;

    assign w_opc = idat[6:2];
    assign w_fmt = fmt_decode(idat[6:0]);
    assign w_ill = (w_fmt == FMT_X);

    t5_immgen #(
        .XLEN (XLEN)
    ) u_immgen (
        .i_idat  (idat[31:7]),
        .i_fmt   (w_fmt),
        .o_imm_c (w_imm)
    );

    // Operand and destination selection for the offered instruction.
    always_comb begin
        w_op1 = rs1d;
        w_op2 = w_imm;
        w_rd  = idat[11:7];
        if (w_ill) begin
            w_op1 = '0;
            w_op2 = '0;
            w_rd  = '0;
        end else begin
            case (w_opc)
                OPC_AUIPC, OPC_JAL, OPC_BRANCH: w_op1 = pc;
                OPC_LUI:                        w_op1 = '0;
                default:                        w_op1 = rs1d;
            endcase
            case (w_opc)
                OPC_STORE, OPC_BRANCH, OPC_MISC_MEM: w_rd = '0;
                default:                             w_rd = idat[11:7];
            endcase
            if (w_fmt == FMT_R) begin
                w_op2 = rs2d;
            end
        end
    end

    // Hart ID bits ride along unchanged; only the upper field increments and wraps.
    assign w_pc_hi = pc[XLEN-1:HBIT] + UPW'(1);
    assign w_pcn   = {w_pc_hi, pc[HBIT-1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= 1'b0;
        end else if (w_xin) begin
            r_vld <= 1'b1;
        end else if (w_xout) begin
            r_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op1  <= '0;
            r_op2  <= '0;
            r_cp1  <= '0;
            r_cp2  <= '0;
            r_aslc <= '0;
            r_fun3 <= '0;
            r_fun7 <= '0;
            r_rd   <= '0;
            r_hid  <= '0;
            r_ill  <= 1'b0;
            r_pcn  <= '0;
            r_npc  <= '0;
            r_pc4  <= '0;
        end else if (w_xin) begin
            r_op1  <= w_op1;
            r_op2  <= w_op2;
            r_cp1  <= rs1d;
            r_cp2  <= rs2d;
            r_aslc <= idat[6:2];
            r_fun3 <= idat[14:12];
            r_fun7 <= idat[31:25];
            r_rd   <= w_rd;
            r_hid  <= pc[HBIT-1:0];
            r_ill  <= w_ill;
            r_pcn  <= w_pcn;
            r_npc  <= r_pcn;
            r_pc4  <= r_npc;
        end
    end

    assign o_vld = r_vld;
    assign op1   = r_op1;
    assign op2   = r_op2;
    assign cp1   = r_cp1;
    assign cp2   = r_cp2;
    assign aslc  = r_aslc;
    assign fun3  = r_fun3;
    assign fun7  = r_fun7;
    assign rd    = r_rd;
    assign hid   = r_hid;
    assign ill   = r_ill;
    assign pcn   = r_pcn;
    assign npc   = r_npc;
    assign pc4   = r_pc4;

endmodule
